scan_pattern_runner: RTL and testbench

- On-chip scan pattern runner that replaces simulator-driven load_unload/capture sequencing for the cpu scan chains.
- Streams load/expected/mask vectors from a host or ROM, shifts NCHAINS parallel chains, issues capture pulses, and compares unload data.
- Reports pass/fail, a saturating fail count and the first-failure location.
- Sits between pattern memory and the cpu test_mode_i / scan_enable_i / scan chain pins.

---
 rtl/scan_pattern_runner_if.sv | 37 +++
 rtl/scan_pattern_runner.sv | 217 +++++++++++++++++++++
 tb/tb_scan_pattern_runner.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/scan_pattern_runner_if.sv
// rtl/scan_pattern_runner_if.sv - pattern vector stream between pattern memory and the scan runner
//
// Purpose: carries one scan vector word per shift cycle from the pattern
// source (host or ROM) to the runner with a valid/ready handshake.
// Signals:
//   pat_valid  source -> runner  vector word valid
//   pat_ready  runner -> source  runner accepts vector word
//   pat_load   source -> runner  scan-in bits for this shift (one per chain)
//   pat_exp    source -> runner  expected scan-out bits
//   pat_mask   source -> runner  1 = compare this chain
// Modports: master = pattern source, slave = runner.

interface scan_pattern_runner_if #(
  parameter int NCHAINS = 4
);
  logic               pat_valid;
  logic               pat_ready;
  logic [NCHAINS-1:0] pat_load;
  logic [NCHAINS-1:0] pat_exp;
  logic [NCHAINS-1:0] pat_mask;

  modport master (
    output pat_valid,
    output pat_load,
    output pat_exp,
    output pat_mask,
    input  pat_ready
  );

  modport slave (
    input  pat_valid,
    input  pat_load,
    input  pat_exp,
    input  pat_mask,
    output pat_ready
  );
endinterface

// File: rtl/scan_pattern_runner.sv
// rtl/scan_pattern_runner.sv - on-chip scan load/capture/unload sequencer with compare
//
// Purpose: streams load/expected/mask words from pattern memory, shifts NCHAINS
// parallel scan chains, issues capture pulses between frames and compares the
// unloaded data, reporting pass/fail, a saturating miscompare count and the
// location of the first miscompare.
//
// Optional feature macro: SCAN_RUNNER_STOP_ON_FAIL_EN adds stop_on_fail_i;
// when high the first miscompare ends the run (DONE on the next cycle).
//
// Ports:
//   clk_i, res_i          clock, synchronous active-high reset
//   start_i, npat_i       start a run of npat_i patterns (IDLE/DONE only)
//   stop_on_fail_i        (macro only) end the run at the first miscompare
//   pat                   pattern stream (slave side of scan_pattern_runner_if)
//   test_mode_o           cpu test mode, high in SHIFT and CAPTURE
//   scan_enable_o         cpu scan enable, high in SHIFT
//   scan_clk_en_o         cpu clock gate for one shift/capture edge
//   scan_in_o/scan_out_i  chain inputs / chain outputs
//   busy_o, done_o, pass_o  run status
//   fail_cnt_o            saturating miscompare-cycle count
//   first_fail_pat_o/vec_o/bits_o  pattern, shift index and masked XOR of first miscompare

module scan_pattern_runner #(
  parameter  int NCHAINS        = 4,
  parameter  int CHAIN_LEN      = 32,
  parameter  int CAPTURE_CYCLES = 1,
  parameter  int PAT_W          = 16,
  localparam int SHW            = $clog2(CHAIN_LEN)
) (
  input  logic               clk_i,
  input  logic               res_i,
  input  logic               start_i,
  input  logic [PAT_W-1:0]   npat_i,
`ifdef SCAN_RUNNER_STOP_ON_FAIL_EN
  input  logic               stop_on_fail_i,
`endif
  scan_pattern_runner_if.slave pat,
  output logic               test_mode_o,
  output logic               scan_enable_o,
  output logic               scan_clk_en_o,
  output logic [NCHAINS-1:0] scan_in_o,
  input  logic [NCHAINS-1:0] scan_out_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               pass_o,
  output logic [15:0]        fail_cnt_o,
  output logic [PAT_W-1:0]   first_fail_pat_o,
  output logic [SHW-1:0]     first_fail_vec_o,
  output logic [NCHAINS-1:0] first_fail_bits_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   f_q, f_d;          // frame counter, 0..npat
  logic [SHW-1:0]     s_q, s_d;          // shift index within the frame
  logic [3:0]         cap_q, cap_d;      // capture cycle counter
  logic [PAT_W-1:0]   npat_q, npat_d;
  logic [15:0]        fail_cnt_q, fail_cnt_d;
  logic [PAT_W-1:0]   ff_pat_q, ff_pat_d;
  logic [SHW-1:0]     ff_vec_q, ff_vec_d;
  logic [NCHAINS-1:0] ff_bits_q, ff_bits_d;
  logic               test_mode_q, test_mode_d;
  logic               scan_en_q, scan_en_d;

  logic               start_ok;
  logic               xfer;
  logic [NCHAINS-1:0] diff;
  logic               miscmp;
  logic               last_shift;
  logic               last_frame;
  logic               cap_last;
  logic               stop_hit;

  assign start_ok   = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign xfer       = (state_q == ST_SHIFT) && pat.pat_valid;
  assign diff       = (scan_out_i ^ pat.pat_exp) & pat.pat_mask;
  // Frame 0 only loads the chains, so there is nothing valid to compare yet.
  assign miscmp     = xfer && (f_q != '0) && (|diff);
  assign last_shift = (s_q == SHW'(CHAIN_LEN - 1));
  assign last_frame = (f_q == npat_q);
  assign cap_last   = (cap_q == 4'(CAPTURE_CYCLES - 1));

`ifdef SCAN_RUNNER_STOP_ON_FAIL_EN
  assign stop_hit = miscmp && stop_on_fail_i;
`else
  assign stop_hit = 1'b0;
`endif

  // State register and datapath registers.
  always_ff @(posedge clk_i) begin
    if (res_i) begin
      state_q     <= ST_IDLE;
      f_q         <= '0;
      s_q         <= '0;
      cap_q       <= '0;
      npat_q      <= '0;
      fail_cnt_q  <= '0;
      ff_pat_q    <= '0;
      ff_vec_q    <= '0;
      ff_bits_q   <= '0;
      test_mode_q <= 1'b0;
      scan_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      f_q         <= f_d;
      s_q         <= s_d;
      cap_q       <= cap_d;
      npat_q      <= npat_d;
      fail_cnt_q  <= fail_cnt_d;
      ff_pat_q    <= ff_pat_d;
      ff_vec_q    <= ff_vec_d;
      ff_bits_q   <= ff_bits_d;
      test_mode_q <= test_mode_d;
      scan_en_q   <= scan_en_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          state_d = (npat_i == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (stop_hit) begin
          state_d = ST_DONE;
        end else if (xfer && last_shift) begin
          state_d = last_frame ? ST_DONE : ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (cap_last) begin
          state_d = ST_SHIFT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counter and result next-values.
  always_comb begin
    f_d        = f_q;
    s_d        = s_q;
    cap_d      = cap_q;
    npat_d     = npat_q;
    fail_cnt_d = fail_cnt_q;
    ff_pat_d   = ff_pat_q;
    ff_vec_d   = ff_vec_q;
    ff_bits_d  = ff_bits_q;

    if (start_ok) begin
      f_d        = '0;
      s_d        = '0;
      cap_d      = '0;
      npat_d     = npat_i;
      fail_cnt_d = '0;
      ff_pat_d   = '0;
      ff_vec_d   = '0;
      ff_bits_d  = '0;
    end else if (state_q == ST_SHIFT) begin
      if (xfer) begin
        s_d   = last_shift ? '0 : s_q + SHW'(1);
        cap_d = '0;
      end
      if (miscmp) begin
        if (fail_cnt_q != 16'hFFFF) begin
          fail_cnt_d = fail_cnt_q + 16'd1;
        end
        // The count never wraps back to zero, so zero means no earlier miscompare.
        if (fail_cnt_q == '0) begin
          ff_pat_d  = f_q - PAT_W'(1);
          ff_vec_d  = s_q;
          ff_bits_d = diff;
        end
      end
    end else if (state_q == ST_CAPTURE) begin
      cap_d = cap_q + 4'd1;
      if (cap_last) begin
        cap_d = '0;
        f_d   = f_q + PAT_W'(1);
      end
    end

    // Registered from the next state so they line up with the state itself.
    test_mode_d = (state_d == ST_SHIFT) || (state_d == ST_CAPTURE);
    scan_en_d   = (state_d == ST_SHIFT);
  end

  // Output logic. Clock enable and ready are cut by reset so a reset
  // mid-run stops pulsing the cpu clock in the same cycle.
  assign pat.pat_ready = (state_q == ST_SHIFT) && !res_i;

  always_comb begin
    test_mode_o       = test_mode_q;
    scan_enable_o     = scan_en_q;
    scan_clk_en_o     = !res_i && (xfer || (state_q == ST_CAPTURE));
    scan_in_o         = (state_q == ST_SHIFT) ? pat.pat_load : '0;
    busy_o            = (state_q == ST_SHIFT) || (state_q == ST_CAPTURE);
    done_o            = (state_q == ST_DONE);
    pass_o            = (state_q == ST_DONE) && (fail_cnt_q == '0);
    fail_cnt_o        = fail_cnt_q;
    first_fail_pat_o  = ff_pat_q;
    first_fail_vec_o  = ff_vec_q;
    first_fail_bits_o = ff_bits_q;
  end

endmodule

// File: tb/tb_scan_pattern_runner.sv
// tb/tb_scan_pattern_runner.sv - self-checking bench for scan_pattern_runner

module tb_scan_pattern_runner;
  localparam int NCHAINS        = 4;
  localparam int CHAIN_LEN      = 32;
  localparam int CAPTURE_CYCLES = 1;
  localparam int PAT_W          = 16;
  localparam int MAXPAT         = 8;

  logic                         clk = 1'b0;
  logic                         res = 1'b0;
  logic                         start = 1'b0;
  logic [PAT_W-1:0]             npat = '0;
  logic                         test_mode_o, scan_enable_o, scan_clk_en_o;
  logic [NCHAINS-1:0]           scan_in_o, scan_out;
  logic                         busy_o, done_o, pass_o;
  logic [15:0]                  fail_cnt_o;
  logic [PAT_W-1:0]             first_fail_pat_o;
  logic [$clog2(CHAIN_LEN)-1:0] first_fail_vec_o;
  logic [NCHAINS-1:0]           first_fail_bits_o;

  int checks = 0;
  int errors = 0;

  scan_pattern_runner_if #(.NCHAINS(NCHAINS)) pif ();

  scan_pattern_runner #(
    .NCHAINS(NCHAINS), .CHAIN_LEN(CHAIN_LEN),
    .CAPTURE_CYCLES(CAPTURE_CYCLES), .PAT_W(PAT_W)
  ) dut (
    .clk_i(clk), .res_i(res), .start_i(start), .npat_i(npat),
    .pat(pif),
    .test_mode_o(test_mode_o), .scan_enable_o(scan_enable_o),
    .scan_clk_en_o(scan_clk_en_o), .scan_in_o(scan_in_o), .scan_out_i(scan_out),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .fail_cnt_o(fail_cnt_o),
    .first_fail_pat_o(first_fail_pat_o), .first_fail_vec_o(first_fail_vec_o),
    .first_fail_bits_o(first_fail_bits_o)
  );

  always #5 clk = ~clk;

  // Ideal cpu scan chains: shift toward the top flop while scan enabled,
  // capture inverts every flop. Sampled between edges, applied on the edge.
  logic [CHAIN_LEN-1:0] chain [NCHAINS];
  logic [NCHAINS-1:0]   inj_bits = '0;
  int                   shift_pulses = 0;
  int                   cap_pulses = 0;
  logic                 mon_en, mon_se;
  logic [NCHAINS-1:0]   mon_in;

  initial begin
    for (int c = 0; c < NCHAINS; c++) chain[c] = '0;
    forever begin
      @(negedge clk);
      #3;
      mon_en = scan_clk_en_o;
      mon_se = scan_enable_o;
      mon_in = scan_in_o;
      @(posedge clk);
      if (mon_en === 1'b1) begin
        if (mon_se === 1'b1) begin
          shift_pulses++;
          for (int c = 0; c < NCHAINS; c++) chain[c] <= {chain[c][CHAIN_LEN-2:0], mon_in[c]};
        end else begin
          cap_pulses++;
          for (int c = 0; c < NCHAINS; c++) chain[c] <= ~chain[c];
        end
      end
    end
  end

  always_comb begin
    scan_out = '0;
    for (int c = 0; c < NCHAINS; c++) scan_out[c] = chain[c][CHAIN_LEN-1] ^ inj_bits[c];
  end

  logic [NCHAINS-1:0] load_mem [MAXPAT][CHAIN_LEN];
  int                 m_cnt, m_pat, m_vec;
  logic [NCHAINS-1:0] m_bits;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_pass"}, pass_o, 0);
    check({tag, "_fail_cnt"}, fail_cnt_o, 0);
    check({tag, "_ff_pat"}, first_fail_pat_o, 0);
    check({tag, "_ff_vec"}, first_fail_vec_o, 0);
    check({tag, "_ff_bits"}, first_fail_bits_o, 0);
    check({tag, "_test_mode"}, test_mode_o, 0);
    check({tag, "_scan_en"}, scan_enable_o, 0);
    check({tag, "_clk_en"}, scan_clk_en_o, 0);
    check({tag, "_ready"}, pif.pat_ready, 0);
    check({tag, "_scan_in"}, scan_in_o, 0);
  endtask

  // One full run: the host presents word (frame f, shift s) until it is taken.
  // The model predicts miscompares from the deliberate exp flips and
  // scan-out injections the host itself introduced.
  task automatic run(input int np, input int stall_pct, input int flip_pct,
                     input bit rand_mask, input logic [NCHAINS-1:0] fixed_mask,
                     input bit inj_en, input int inj_pat, input int inj_vec,
                     input int inj_chain, input bit busy_start, input string tag);
    int f, s, cycles, sp0, cp0;
    bit xfer, fin;
    logic [NCHAINS-1:0] flip, mask, inv, d;
    inv = (CAPTURE_CYCLES % 2 == 1) ? '1 : '0;
    for (int p = 0; p < np; p++)
      for (int k = 0; k < CHAIN_LEN; k++) load_mem[p][k] = NCHAINS'($urandom);
    m_cnt = 0; m_pat = 0; m_vec = 0; m_bits = '0;
    sp0 = shift_pulses; cp0 = cap_pulses;
    @(negedge clk);
    start = 1'b1; npat = PAT_W'(np);
    @(negedge clk);
    start = 1'b0;
    f = 0; s = 0; cycles = 0; fin = 1'b0;
    while (!fin && cycles < 20000) begin
      pif.pat_valid = ($urandom_range(99) >= stall_pct);
      flip = ($urandom_range(99) < flip_pct) ? NCHAINS'($urandom) : '0;
      mask = rand_mask ? NCHAINS'($urandom) : fixed_mask;
      pif.pat_load = (f < np) ? load_mem[f][s] : NCHAINS'($urandom);
      pif.pat_exp  = (f > 0) ? (load_mem[f-1][s] ^ inv ^ flip) : NCHAINS'($urandom);
      pif.pat_mask = mask;
      inj_bits = (inj_en && f == inj_pat + 1 && s == inj_vec) ? NCHAINS'(1 << inj_chain) : '0;
      start = busy_start && (f == 3) && (s == 0);
      if (start) npat = '0;
      #1;
      if (pif.pat_ready === 1'b1 && !pif.pat_valid) begin
        check({tag, "_stall_clk_en"}, scan_clk_en_o, 0);
        check({tag, "_stall_scan_en"}, scan_enable_o, 1);
      end
      xfer = pif.pat_valid && (pif.pat_ready === 1'b1);
      if (xfer && f > 0) begin
        d = (inj_bits ^ flip) & mask;
        if (d != '0) begin
          if (m_cnt == 0) begin
            m_pat = f - 1; m_vec = s; m_bits = d;
          end
          m_cnt++;
        end
      end
      @(negedge clk);
      cycles++;
      if (xfer) begin
        s++;
        if (s == CHAIN_LEN) begin
          s = 0; f++;
        end
      end
      fin = (done_o === 1'b1);
    end
    pif.pat_valid = 1'b0; start = 1'b0; inj_bits = '0;
    #1;
    check({tag, "_done"}, done_o, 1);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_test_mode"}, test_mode_o, 0);
    check({tag, "_shift_pulses"}, shift_pulses - sp0, (np + 1) * CHAIN_LEN);
    check({tag, "_cap_pulses"}, cap_pulses - cp0, np * CAPTURE_CYCLES);
    if (stall_pct == 0)
      check({tag, "_cycles"}, cycles, (np + 1) * CHAIN_LEN + np * CAPTURE_CYCLES);
    check({tag, "_fail_cnt"}, fail_cnt_o, m_cnt);
    check({tag, "_pass"}, pass_o, (m_cnt == 0));
    check({tag, "_ff_pat"}, first_fail_pat_o, m_pat);
    check({tag, "_ff_vec"}, first_fail_vec_o, m_vec);
    check({tag, "_ff_bits"}, first_fail_bits_o, m_bits);
    repeat (3) @(negedge clk);
    #1;
    check({tag, "_hold_done"}, done_o, 1);
    check({tag, "_hold_fail_cnt"}, fail_cnt_o, m_cnt);
  endtask

  int sp_snap;

  initial begin
    pif.pat_valid = 1'b0;
    pif.pat_load  = '0;
    pif.pat_exp   = '0;
    pif.pat_mask  = '0;

    // Power-on reset.
    res = 1'b1;
    repeat (2) @(negedge clk);
    res = 1'b0;
    #1;
    check_idle("reset");

    // Clean run, ideal chains, all chains compared.
    run(3, 0, 0, 1'b0, 4'hF, 1'b0, 0, 0, 0, 1'b0, "clean");

    // Single flip on chain 2 at pattern 1 shift 5, plus start pulses while busy.
    run(3, 0, 0, 1'b0, 4'hF, 1'b1, 1, 5, 2, 1'b1, "inject");
    check("inject_const_cnt", fail_cnt_o, 1);
    check("inject_const_pat", first_fail_pat_o, 1);
    check("inject_const_vec", first_fail_vec_o, 5);
    check("inject_const_bits", first_fail_bits_o, 4'b0100);
    check("inject_const_pass", pass_o, 0);

    // Same flip with chain 2 masked out.
    run(3, 0, 0, 1'b0, 4'hB, 1'b1, 1, 5, 2, 1'b0, "masked");
    check("masked_const_pass", pass_o, 1);

    // Same flip with 50% valid stalls: identical results.
    run(3, 50, 0, 1'b0, 4'hF, 1'b1, 1, 5, 2, 1'b0, "stall");
    check("stall_const_cnt", fail_cnt_o, 1);
    check("stall_const_vec", first_fail_vec_o, 5);
    check("stall_const_bits", first_fail_bits_o, 4'b0100);

    // Randomized runs: random exp corruption, masks and stalls.
    for (int i = 0; i < 3; i++)
      run($urandom_range(5, 1), 30, 15, 1'b1, 4'h0, 1'b0, 0, 0, 0, 1'b0, "rand");

    // npat = 0: DONE one cycle after start, previous results cleared.
    @(negedge clk);
    sp_snap = shift_pulses + cap_pulses;
    start = 1'b1; npat = '0;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("npat0_done", done_o, 1);
    check("npat0_pass", pass_o, 1);
    check("npat0_busy", busy_o, 0);
    check("npat0_fail_cnt", fail_cnt_o, 0);
    repeat (2) @(negedge clk);
    check("npat0_pulses", shift_pulses + cap_pulses - sp_snap, 0);

    // Reset in the middle of SHIFT.
    start = 1'b1; npat = PAT_W'(3);
    @(negedge clk);
    start = 1'b0;
    pif.pat_valid = 1'b1;
    repeat (10) begin
      pif.pat_load = NCHAINS'($urandom);
      @(negedge clk);
    end
    #1;
    check("midrst_busy_before", busy_o, 1);
    res = 1'b1;
    @(negedge clk);
    sp_snap = shift_pulses + cap_pulses;
    @(negedge clk);
    res = 1'b0;
    #1;
    check_idle("midrst");
    repeat (5) @(negedge clk);
    #1;
    check("midrst_no_pulses", shift_pulses + cap_pulses - sp_snap, 0);
    check("midrst_still_idle", busy_o, 0);
    pif.pat_valid = 1'b0;

    // Recovery after the aborted run.
    run(2, 20, 10, 1'b1, 4'h0, 1'b0, 0, 0, 0, 1'b0, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
